// File: rtl/glb_pkg.sv
// Shared types for the GLB write-back path: tag type, collector FSM states
// and a sign-extension helper for psum-to-accumulator widening.
package glb_pkg;

  localparam int NUM_COL = 4;
  localparam int TAG_W   = $clog2(NUM_COL);
  localparam int PSUM_W  = 16;
  localparam int ACC_W   = 2 * PSUM_W;

  typedef logic [TAG_W-1:0] tag_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } collector_state_e;

  // Widen a default-width psum to the default accumulator width.
  function automatic logic [ACC_W-1:0] sext(input logic [PSUM_W-1:0] v);
    return {{(ACC_W - PSUM_W){v[PSUM_W-1]}}, v};
  endfunction

endpackage

// File: rtl/glb_result_fifo.sv
// Synchronous first-word-fall-through FIFO with synchronous clear.
// The head word is always visible on dout; dout reads 0 while empty.
module glb_result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit separates full from empty when the indices match.
  logic [AW:0]                  wr_q, rd_q;
  logic [DEPTH-1:0][WIDTH-1:0] mem_q;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout  = empty ? '0 : mem_q[rd_q[AW-1:0]];

  // Pointer update; clear dominates any push or pop in the same cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (clear) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push && !full)  wr_q <= wr_q + 1'b1;
      if (pop  && !empty) rd_q <= rd_q + 1'b1;
    end
  end

  // Storage write; contents are don't-care until the pointers cover them.
  always_ff @(posedge clk) begin
    if (push && !full && !clear) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/glb_psum_collector.sv
// Receive end of the P2P psum chain: filters psums by column tag, reduces
// every kernel_size matched psums into one sum and queues results for the
// global buffer write port.
module glb_psum_collector
  import glb_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_COL    = 4,
  parameter int ACC_WIDTH  = 2 * DATA_WIDTH,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       en,
  input  logic                       flush,
  input  logic [7:0]                 kernel_size,
  input  logic [$clog2(NUM_COL)-1:0] ID,
  input  logic                       pe_valid,
  output logic                       pe_ready,
  input  logic [$clog2(NUM_COL)-1:0] pe_tag,
  input  logic [DATA_WIDTH-1:0]      pe_psum,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_WIDTH-1:0]       out_data,
  output logic                       busy,
  output logic [7:0]                 drop_cnt
);

  collector_state_e     state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [7:0]           ks_q, ks_d;
  logic [7:0]           drop_q, drop_d;

  logic                 fifo_full, fifo_empty;
  logic                 accept, match, push;
  logic [ACC_WIDTH-1:0] push_data, psum_ext, sum;
  logic [7:0]           ks_eff;

  // rstn gates pe_ready so it drops the instant reset asserts.
  assign pe_ready  = rstn & en & ~flush & ~fifo_full;
  assign accept    = pe_valid & pe_ready;
  assign match     = (pe_tag == ID);
  assign psum_ext  = {{(ACC_WIDTH - DATA_WIDTH){pe_psum[DATA_WIDTH-1]}}, pe_psum};
  assign sum       = acc_q + psum_ext;
  assign ks_eff    = (kernel_size == 8'd0) ? 8'd1 : kernel_size;
  assign out_valid = ~fifo_empty;
  assign busy      = (state_q == ACCUM) | ~fifo_empty;
  assign drop_cnt  = drop_q;

  // Next-state: flush clears everything; mismatched tags only bump drop_cnt.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ks_d      = ks_q;
    drop_d    = drop_q;
    push      = 1'b0;
    push_data = '0;
    if (flush) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      drop_d  = '0;
    end else if (accept) begin
      if (!match) begin
        if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
      end else begin
        case (state_q)
          IDLE: begin
            ks_d = ks_eff;
            if (ks_eff == 8'd1) begin
              push      = 1'b1;
              push_data = psum_ext;
            end else begin
              acc_d   = psum_ext;
              cnt_d   = 8'd1;
              state_d = ACCUM;
            end
          end
          ACCUM: begin
            if ({1'b0, cnt_q} + 9'd1 == {1'b0, ks_q}) begin
              push      = 1'b1;
              push_data = sum;
              acc_d     = '0;
              cnt_d     = '0;
              state_d   = IDLE;
            end else begin
              acc_d = sum;
              cnt_d = cnt_q + 8'd1;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ks_q    <= 8'd1;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ks_q    <= ks_d;
      drop_q  <= drop_d;
    end
  end

  glb_result_fifo #(
    .WIDTH (ACC_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .clear (flush),
    .push  (push),
    .din   (push_data),
    .pop   (out_ready & ~fifo_empty & ~flush),
    .dout  (out_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_glb_psum_collector.sv
// Scenario bench for glb_psum_collector: expected results are queued as
// stimulus is driven and a negedge monitor checks every popped result.
module tb_glb_psum_collector;

  logic        clk, rstn, en, flush;
  logic [7:0]  kernel_size;
  logic [1:0]  ID, pe_tag;
  logic        pe_valid, pe_ready, out_valid, out_ready, busy;
  logic [15:0] pe_psum;
  logic [31:0] out_data;
  logic [7:0]  drop_cnt;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  glb_psum_collector #(
    .DATA_WIDTH(16), .NUM_COL(4), .ACC_WIDTH(32), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .rstn(rstn), .en(en), .flush(flush),
    .kernel_size(kernel_size), .ID(ID),
    .pe_valid(pe_valid), .pe_ready(pe_ready), .pe_tag(pe_tag), .pe_psum(pe_psum),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: a pop happens on the next rising edge when this holds.
  always @(negedge clk) begin
    if (rstn && !flush && out_valid && out_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected got=%h want=<none>", out_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          fails++;
          $display("FAIL sb_data got=%h want=%h", out_data, e);
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [1:0] tag, input logic [15:0] d);
    int n = 0;
    pe_valid = 1'b1; pe_tag = tag; pe_psum = d;
    @(negedge clk);
    while (!pe_ready && n < 100) begin n++; @(negedge clk); end
    if (!pe_ready) begin
      tests++; fails++;
      $display("FAIL send_timeout got=pe_ready 0 want=1");
    end
    @(posedge clk); #1;
    pe_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin n++; @(negedge clk); end
    tests++;
    if (exp_q.size() != 0 || out_valid) begin
      fails++;
      $display("FAIL drain got=%0d pending want=0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; en = 1'b1; flush = 1'b0; kernel_size = 8'd3; ID = 2'd1;
    pe_valid = 1'b1; pe_tag = 2'd1; pe_psum = 16'd0; out_ready = 1'b1;
    #1;
    tests++;
    if (pe_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'd0 ||
        busy !== 1'b0 || drop_cnt !== 8'd0) begin
      fails++;
      $display("FAIL reset got=rdy%b vld%b data%h busy%b drop%0d want=all 0",
               pe_ready, out_valid, out_data, busy, drop_cnt);
    end
    pe_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    kernel_size = 8'd3; out_ready = 1'b1;
    exp_q.push_back(32'd10);
    send(2'd1, 16'd5);
    send(2'd1, -16'sd2);
    send(2'd1, 16'd7);
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b1 || out_data !== 32'd10) begin
      fails++;
      $display("FAIL basic_latency got=vld%b data%h want=vld1 data0000000a", out_valid, out_data);
    end
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL basic_busy got=%b want=0", busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_tag_filter();
    kernel_size = 8'd3; out_ready = 1'b1;
    exp_q.push_back(32'd10);
    send(2'd1, 16'd5);
    send(2'd3, 16'd100);
    send(2'd1, -16'sd2);
    send(2'd1, 16'd7);
    wait_drain();
    tests++;
    if (drop_cnt !== 8'd1) begin
      fails++;
      $display("FAIL tag_drop got=%0d want=1", drop_cnt);
    end
  endtask

  task automatic test_backpressure();
    kernel_size = 8'd1; out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) exp_q.push_back(i);
    for (int i = 1; i <= 8; i++) send(2'd1, 16'(i));
    pe_valid = 1'b1; pe_tag = 2'd1; pe_psum = 16'd9;
    @(negedge clk);
    tests++;
    if (pe_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'd1) begin
      fails++;
      $display("FAIL bp_full got=rdy%b vld%b data%h want=rdy0 vld1 data00000001",
               pe_ready, out_valid, out_data);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(2'd1, 16'd9);
    wait_drain();
  endtask

  task automatic test_flush();
    kernel_size = 8'd3; out_ready = 1'b1;
    send(2'd1, 16'd4);
    send(2'd2, 16'd9);
    send(2'd1, 16'd4);
    flush = 1'b1;
    @(negedge clk);
    tests++;
    if (pe_ready !== 1'b0) begin
      fails++;
      $display("FAIL flush_ready got=%b want=0", pe_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || drop_cnt !== 8'd0) begin
      fails++;
      $display("FAIL flush_clear got=busy%b drop%0d want=busy0 drop0", busy, drop_cnt);
    end
    @(posedge clk); #1;
    exp_q.push_back(32'd3);
    for (int i = 0; i < 3; i++) send(2'd1, 16'd1);
    wait_drain();
  endtask

  task automatic test_sign_ks0();
    out_ready = 1'b1;
    kernel_size = 8'd0;
    exp_q.push_back(32'hFFFF8000);
    send(2'd1, 16'h8000);
    kernel_size = 8'd3;
    exp_q.push_back(32'hFFFE8000);
    for (int i = 0; i < 3; i++) send(2'd1, 16'h8000);
    wait_drain();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    kernel_size = 8'd1;
    send(2'd1, 16'd7);
    kernel_size = 8'd3;
    send(2'd1, 16'd1);
    @(negedge clk);
    tests++;
    if (busy !== 1'b1 || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL ar_pre got=busy%b vld%b want=busy1 vld1", busy, out_valid);
    end
    #2 rstn = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || pe_ready !== 1'b0 || busy !== 1'b0 || out_data !== 32'd0) begin
      fails++;
      $display("FAIL ar_immediate got=vld%b rdy%b busy%b data%h want=0",
               out_valid, pe_ready, busy, out_data);
    end
    exp_q.delete();
    @(negedge clk); #2 rstn = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    kernel_size = 8'd2;
    exp_q.push_back(32'd5);
    send(2'd1, 16'd2);
    send(2'd1, 16'd3);
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tag_filter();
    test_backpressure();
    test_flush();
    test_sign_ks0();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Backstop so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/glb_psum_collector.md
Name: glb_psum_collector

Overview:
- Receive end of the PE-to-PE (P2P) psum chain. Sits after the last glb_PE in a column loop and consumes that PE's output VALID/READY stream.
- Accepts psums whose tag matches this collector's column ID and reduces every kernel_size accepted psums into one accumulated result.
- Buffers results in a small FIFO and presents them to the global buffer write port over a valid/ready handshake.

Parameters:
- DATA_WIDTH, 16, width of one incoming psum (signed two's complement)
- NUM_COL, 4, number of PE columns; sets tag/ID width = $clog2(NUM_COL)
- ACC_WIDTH, 2*DATA_WIDTH, width of accumulator and output result
- FIFO_DEPTH, 8, result FIFO entries (power of two, >=2)

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- en  in  1  collector enable; no accepts while low
- flush  in  1  synchronous clear pulse
- kernel_size  in  8  psums per result; value 0 treated as 1
- ID  in  $clog2(NUM_COL)  this collector's column ID
- pe_valid  in  1  upstream PE psum valid
- pe_ready  out  1  collector can accept
- pe_tag  in  $clog2(NUM_COL)  tag carried with psum
- pe_psum  in  DATA_WIDTH  signed psum
- out_valid  out  1  FIFO head valid
- out_ready  in  1  global buffer accepts head
- out_data  out  ACC_WIDTH  accumulated result (FIFO head)
- busy  out  1  group in progress or FIFO non-empty
- drop_cnt  out  8  count of tag-mismatched psums, saturating at 255

Behaviour:
- Reset (rstn low, async): FSM=IDLE; acc, grp_cnt, FIFO pointers and drop_cnt cleared. Outputs pe_ready=0, out_valid=0, out_data=0, busy=0, drop_cnt=0, taking effect immediately.
- Accept handshake: accept = pe_valid & pe_ready.
  - pe_ready = en & ~flush & ~fifo_full (combinational).
  - pe_valid may be held without pe_ready; the collector never accepts while pe_ready=0.
- Tag filter: on accept with pe_tag!=ID, the psum is consumed and discarded; drop_cnt++ (saturate at 255). No effect on acc, grp_cnt or FSM.
- FSM states:
  - IDLE: grp_cnt=0. A matched accept latches ks=max(kernel_size,1).
    - If ks==1: push sext(pe_psum) to the FIFO and stay in IDLE.
    - Otherwise: acc=sext(pe_psum), grp_cnt=1, go to ACCUM.
  - ACCUM: a matched accept sets grp_cnt++ and acc+=sext(pe_psum).
    - When grp_cnt+1==ks: push acc+sext(pe_psum) in the same cycle, clear acc and grp_cnt, go to IDLE.
- kernel_size is sampled only in IDLE on the first matched accept; changes mid-group are ignored.
- Arithmetic: sign-extend the psum to ACC_WIDTH; addition wraps modulo 2^ACC_WIDTH; no saturation.
- Latency: final psum of a group accepted at edge N, FIFO empty → out_valid=1 with the correct out_data after edge N (visible in cycle N+1).
- FIFO: first-word-fall-through; out_data=head whenever out_valid=1, out_data=0 when empty.
  - pop = out_valid & out_ready.
  - Push and pop in the same cycle leave the occupancy unchanged.
  - Push cannot occur when full because pe_ready=0; pop when full is allowed.
  - Order is strictly preserved.
- flush (highest priority after reset): on the edge where flush=1, clear acc, grp_cnt, FIFO and drop_cnt and go to IDLE. No accept or pop occurs that cycle. pe_ready=0 during flush.
- en low mid-group: pe_ready=0; acc and grp_cnt hold; resume on en high. FIFO still drains.
- busy = (state==ACCUM) | ~fifo_empty.

Decomposition:
- glb_pkg (shared): tag_t typedef sized by $clog2(NUM_COL); collector_state_e enum {IDLE, ACCUM}; sext helper function.
- One sub-module: glb_result_fifo (parameterised WIDTH/DEPTH synchronous FWFT FIFO with full/empty/clear, async active-low reset). It is reusable by other write-back paths.

Test Plan:
- Basic group: ID=1, kernel_size=3, psums 5, -2, 7 with tag 1, out_ready=1 → one result out_data=10, out_valid high one cycle after the third accept; busy returns 0.
- Tag filter: same setup with a psum of 100 tagged 3 inserted between 5 and -2 → out_data=10, drop_cnt=1.
- Backpressure: kernel_size=1, out_ready=0, feed 1..9 → pe_ready drops after the 8th accept. Raise out_ready → pops 1..8 in order, then 9 is accepted and emitted.
- Flush mid-group: kernel_size=3, accept 4 and 4, pulse flush for 1 cycle → busy=0, drop_cnt=0. Then 1, 1, 1 → out_data=3.
- Sign extension / kernel_size 0: kernel_size=0, psum -32768 → out_data=32'hFFFF8000. Then kernel_size=3 with three -32768 → out_data=-98304.
- Async reset mid-operation: assert rstn=0 between edges during ACCUM with a non-empty FIFO → out_valid, pe_ready and busy go to 0 immediately. After release, a new group of 2, 3 (kernel_size=2) → out_data=5.
